// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// constants and the queue entry layout.
package fetch_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DROP = 2'b10;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] WORD_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} pairs between memory and IF/ID.
// Flush has priority over push/pop; the head entry is read combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [31:0]             push_pc,
  input  logic [31:0]             push_instr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic [31:0]             head_pc,
  output logic [31:0]             head_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_pop;
  logic               do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  // Pointer and occupancy bookkeeping; a flush empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
  end

  // The fetch FSM gates issue on occupancy, so a push into a full queue
  // without a simultaneous pop indicates broken issue gating.
  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the single-outstanding
// req/ack handshake to instruction memory, buffers returned words and
// presents one instruction per cycle to IF/ID. Taken branches flush the
// queue and turn any in-flight fetch into a drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_addr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pop_req;
  logic             can_issue;
  logic             xfer;
  logic             push;
  logic [31:0]      head_pc;
  logic [31:0]      head_instr;

  // A full queue can still accept a new fetch when its head leaves this
  // cycle. Issue is held off while reset is asserted so imem_req drops
  // asynchronously with it.
  assign pop_req   = !empty && !stall;
  assign can_issue = reset && (!full || pop_req);

  // IDLE presents fetch_pc live; WAIT/DROP replay the captured address so it
  // stays frozen even after a redirect has moved fetch_pc.
  assign imem_addr = (state == ST_IDLE) ? fetch_pc : req_addr;

  // Returned words are kept only when nothing invalidated them: no redirect
  // this cycle and not a wrong-path fetch being drained.
  assign xfer = imem_req && imem_ack;
  assign push = xfer && !branch_taken && (state != ST_DROP);

  // Request is raised by a fresh issue in IDLE and held through WAIT/DROP.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      ST_IDLE:          imem_req = can_issue;
      ST_WAIT, ST_DROP: imem_req = 1'b1;
      default:          imem_req = 1'b0;
    endcase
  end

  // Next-state: completion returns to IDLE; a redirect over a pending
  // request converts it to a drop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (imem_req && !imem_ack) state_nxt = branch_taken ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ack)          state_nxt = ST_IDLE;
        else if (branch_taken) state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (imem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Fetch PC: a redirect wins; otherwise advance one word per kept transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            fetch_pc <= RESET_PC;
    else if (branch_taken) fetch_pc <= word_align(branch_target);
    else if (push)         fetch_pc <= fetch_pc + WORD_INC;
  end

  // Capture the address of each request as it leaves IDLE.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && imem_req) req_addr <= fetch_pc;
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop_req),
    .flush      (branch_taken),
    .push_pc    (imem_addr),
    .push_instr (imem_rdata),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head_instr : NOP_WORD;
  assign pc          = instr_valid ? head_pc : 32'h0000_0000;
  assign pc_plus4    = pc + WORD_INC;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait and delayed memory, decode stall,
// redirects during wait/ack, reset during a transfer and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int mem_lat  = 0;
  int wait_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed, address-dependent pattern.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  // Memory model: acks once the request has waited mem_lat cycles.
  assign imem_rdata = rom(imem_addr);
  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);

  always @(posedge clk or negedge reset) begin
    if (!reset)                   wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // IF/ID-facing outputs for either a valid head at address p or an empty queue.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] p);
    logic [31:0] e_pc;
    e_pc = v ? p : 32'h0;
    check_val({tag, "_valid"}, instr_valid, v);
    check_val({tag, "_pc"}, pc, e_pc);
    check_val({tag, "_instr"}, instr, v ? rom(p) : 32'h0);
    check_val({tag, "_pc4"}, pc_plus4, e_pc + 32'd4);
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
    check_val({tag, "_req"}, imem_req, r);
    if (r) check_val({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    logic [31:0] e_addr;
    logic [31:0] e_pc;

    // Reset state
    tick(); tick(); #1;
    expect_req("rst", 1'b0, 32'h0);
    check_val("rst_addr", imem_addr, 32'h0);
    expect_out("rst", 1'b0, 32'h0);

    // 1: zero-wait memory, one instruction per cycle from 0
    reset = 1'b1; #1;
    expect_req("t1_first", 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      e_pc = 32'(k * 4);
      expect_out("t1", 1'b1, e_pc);
      expect_req("t1", 1'b1, e_pc + 32'd4);
    end

    // 2: three-cycle ack latency, address held while waiting
    mem_lat = 3; #1;
    for (int n = 0; n < 2; n++) begin
      e_addr = 32'h10 + 32'(n * 4);
      for (int c = 0; c < 4; c++) begin
        expect_req("t2", 1'b1, e_addr);
        if (c == 0) expect_out("t2_head", 1'b1, e_addr - 32'd4);
        else        expect_out("t2_gap", 1'b0, 32'h0);
        tick(); #1;
      end
    end
    expect_out("t2_end", 1'b1, 32'h14);

    // 3: decode stall for 5 cycles, queue fills and fetch stops
    mem_lat = 0; stall = 1'b1; #1;
    expect_req("t3_s0", 1'b1, 32'h18);
    expect_out("t3_s0", 1'b1, 32'h14);
    for (int s = 1; s < 5; s++) begin
      tick(); #1;
      expect_req("t3_full", 1'b0, 32'h0);
      expect_out("t3_frozen", 1'b1, 32'h14);
    end
    tick(); stall = 1'b0; #1;
    expect_out("t3_r0", 1'b1, 32'h14);
    expect_req("t3_r0", 1'b1, 32'h1C);
    tick(); #1;
    expect_out("t3_r1", 1'b1, 32'h18);
    expect_req("t3_r1", 1'b1, 32'h20);
    tick(); #1;
    expect_out("t3_r2", 1'b1, 32'h1C);

    // 6: reset while waiting; late ack after release is a fresh fetch of RESET_PC
    mem_lat = 3; #1;
    tick(); #1;
    expect_req("t6_wait", 1'b1, 32'h24);
    reset = 1'b0; #1;
    expect_req("t6_async", 1'b0, 32'h0);
    check_val("t6_addr", imem_addr, 32'h0);
    expect_out("t6_async", 1'b0, 32'h0);
    mem_lat = 1;
    tick(); tick(); #1;
    expect_req("t6_held", 1'b0, 32'h0);
    reset = 1'b1; #1;
    expect_req("t6_rel", 1'b1, 32'h0);
    tick(); #1;
    expect_req("t6_ack", 1'b1, 32'h0);
    check_val("t6_ackin", imem_ack, 1'b1);
    expect_out("t6_ack", 1'b0, 32'h0);
    tick(); #1;
    expect_out("t6_first", 1'b1, 32'h0);

    // 4: redirect to 0x43 while the fetch of 8 waits (and decode is stalled)
    reset = 1'b0; mem_lat = 0; stall = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    expect_req("t4_c0", 1'b1, 32'h0);
    tick(); stall = 1'b1; #1;
    expect_out("t4_c1", 1'b1, 32'h0);
    expect_req("t4_c1", 1'b1, 32'h4);
    tick(); stall = 1'b0; mem_lat = 2; #1;
    expect_out("t4_c2", 1'b1, 32'h0);
    expect_req("t4_c2", 1'b1, 32'h8);
    tick(); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0043; #1;
    expect_out("t4_c3", 1'b1, 32'h4);
    expect_req("t4_c3", 1'b1, 32'h8);
    tick(); branch_taken = 1'b0; #1;
    expect_out("t4_drop", 1'b0, 32'h0);
    expect_req("t4_drop", 1'b1, 32'h8);
    tick(); mem_lat = 0; stall = 1'b0; #1;
    expect_out("t4_c5", 1'b0, 32'h0);
    expect_req("t4_target", 1'b1, 32'h40);
    tick(); #1;
    expect_out("t4_c6", 1'b1, 32'h40);
    expect_req("t4_c6", 1'b1, 32'h44);

    // 5: redirect coinciding with ack and pop
    branch_taken = 1'b1; branch_target = 32'h0000_1000; #1;
    expect_out("t5_br", 1'b1, 32'h40);
    expect_req("t5_br", 1'b1, 32'h44);
    tick(); branch_taken = 1'b0; #1;
    expect_out("t5_flushed", 1'b0, 32'h0);
    expect_req("t5_target", 1'b1, 32'h1000);
    tick(); #1;
    expect_out("t5_first", 1'b1, 32'h1000);

    // PC wrap: target 0xFFFF_FFFF aligns to 0xFFFF_FFFC, next word is 0
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF; #1;
    tick(); branch_taken = 1'b0; #1;
    expect_req("wrap_target", 1'b1, 32'hFFFF_FFFC);
    tick(); #1;
    expect_out("wrap_top", 1'b1, 32'hFFFF_FFFC);
    expect_req("wrap_next", 1'b1, 32'h0);
    tick(); #1;
    expect_out("wrap_zero", 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small queue, and one instruction per cycle is presented to IF/ID. The stage honours decode stalls and redirects on taken branches, discarding any wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset; bits [1:0] must be 00
DEPTH, 2, instruction-queue entries (power of two, 2 or 4)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  out  1  fetch request valid
imem_addr  out  32  word address of the request; bits [1:0] always 00
imem_ack  in  1  memory accepts the request and returns data this cycle
imem_rdata  in  32  instruction word; valid only when imem_req && imem_ack
stall  in  1  IF/ID not loading this cycle (inverse of its load enable)
branch_taken  in  1  redirect fetch this cycle
branch_target  in  32  redirect address; bits [1:0] ignored and forced to 00
instr_valid  out  1  instr/pc outputs hold a real instruction
instr  out  32  instruction to IF/ID; 32'h0 (NOP) when instr_valid=0
pc  out  32  address of instr
pc_plus4  out  32  pc+4 mod 2^32, used as the link value for BL

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, queue empty, FSM=IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc=0, pc_plus4=4.
- Transfer: completes on a cycle where imem_req && imem_ack; imem_rdata is sampled at that edge.
  - Ack may arrive in the same cycle req rises (zero-wait) or any number of cycles later.
  - While req=1 and ack=0, imem_addr must not change.
  - At most one request outstanding.
- FSM, 3 states:
  - IDLE: req=0. Issue (req=1, addr=fetch_pc) when count + 0 < DEPTH. On issue, go to WAIT if ack=0. If ack=1 the transfer completes and the FSM stays in IDLE.
  - WAIT: req=1. On ack, push {imem_rdata, fetch_pc}, fetch_pc += 4, go to IDLE. Back-to-back: a new request may issue the following cycle.
  - DROP: req=1, same address held. On ack, discard the data and go to IDLE. fetch_pc already holds the branch target.
- Queue and consume:
  - Head entry drives instr/pc/pc_plus4 combinationally. instr_valid = (count != 0).
  - Pop when instr_valid && !stall. Push and pop in the same cycle is allowed; count is unchanged.
  - Issue gating: a request issues only if count < DEPTH, or count == DEPTH with a pop this cycle.
  - Never push when full. Overflow is an assertion failure.
- Redirect (branch_taken=1), priority over everything else in that cycle:
  - Queue cleared: count=0, no pop is counted. instr_valid=0 from the next cycle.
  - fetch_pc <= {branch_target[31:2],2'b00}.
  - In WAIT without ack: go to DROP, request continues.
  - In WAIT or IDLE with ack this cycle: the returning word is discarded and the FSM goes to IDLE.
  - In DROP: stay in DROP; the target is updated to the newest one.
  - New request to the target issues no earlier than the cycle after redirect.
  - Redirect during stall=1 is still honoured.
- Arithmetic: all PC math is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset mid-transfer: the outstanding request is abandoned. imem_req drops asynchronously, and any late ack after reset release is ignored because the FSM is in IDLE.

Decomposition:
- Shared package fetch_pkg:
  - state encoding IDLE=2'b00, WAIT=2'b01, DROP=2'b10
  - NOP_WORD=32'h0
  - WORD_INC=32'd4
- Sub-module fetch_queue: synchronous FIFO of {pc[31:0], instr[31:0]}.
  - Inputs: push, pop, flush.
  - Outputs: count, full, empty, head data.
  - Same async active-low reset.
- Top level holds the FSM, fetch_pc and issue gating.

Test Plan:
1. Zero-wait memory (ack tied 1), stall=0, from reset release → pc sequence 0,4,8,C on consecutive cycles; instr matches ROM words; pc_plus4 = pc+4.
2. Ack delayed 3 cycles per request → imem_addr held constant during each wait; one instruction every 4 cycles; no duplicate or skipped pc.
3. stall=1 for 5 cycles with zero-wait memory → queue fills to DEPTH=2, imem_req=0 while full, instr/pc frozen. On release, pops resume in order 0,4,8 with no loss.
4. branch_taken with target 32'h0000_0043 while request to 8 is pending (ack 2 cycles later) → FSM enters DROP, word at 8 is discarded, queue is flushed, next issued address is 32'h40, first valid pc=0x40.
5. branch_taken in the same cycle as ack and pop → returned word dropped, instr_valid=0 next cycle, next fetch is the target.
6. reset driven low while in WAIT, ack asserted one cycle after release → imem_req=0 immediately, ack ignored, first request after release is RESET_PC.
